ccr_unit: RTL and testbench

Condition-code register stage sitting directly downstream of the execute-stage ALU. It latches the ALU's combinational {C,N,Z} result into the architectural flag register. It clears the tested flag when a conditional jump is taken, and saves and restores flags across interrupt entry and RTI through a shadow stack. Its registered `ccr` output is fed back to the ALU as the previous-flags input.

---
 rtl/ccr_unit.sv | 121 ++++++++++++
 tb/tb_ccr_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ccr_unit.sv
// Condition-code register stage: latches ALU {C,N,Z}, clears tested flag on taken jumps,
// and saves/restores flags across interrupts. Define CCR_NEST_EN for a DEPTH-entry shadow stack.
module ccr_unit #(
  parameter int DEPTH = 4,
  parameter int DW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flag_we,
  input  logic [2:0]    alu_ccr,
  input  logic [4:0]    alu_op,
  input  logic          jump_taken,
  input  logic          int_save,
  input  logic          rti_restore,
  output logic [2:0]    ccr,
  output logic [DW-1:0] depth,
  output logic          ovf_err,
  output logic          unf_err
);

  localparam logic [4:0] OP_JZ = 5'd20;
  localparam logic [4:0] OP_JN = 5'd21;
  localparam logic [4:0] OP_JC = 5'd22;

  logic [2:0] ccr_q;
  logic [2:0] ccr_n;

  // Normal next value: fresh ALU flags or held flags, minus the flag a taken jump tested.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    ccr_n = flag_we ? alu_ccr : ccr_q;
    if (jump_taken) begin
      case (alu_op)
        OP_JZ:   ccr_n[0] = 1'b0;
        OP_JN:   ccr_n[1] = 1'b0;
        OP_JC:   ccr_n[2] = 1'b0;
        default: ;
      endcase
    end
  end

`ifdef CCR_NEST_EN
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [2:0]    stack_q [DEPTH];
  logic [DW-1:0] depth_q;
  logic          ovf_q;
  logic          unf_q;
  logic [DW-1:0] depth_m1;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic          full;
  logic          empty;

  always_comb begin
    depth_m1 = depth_q - DW'(1);
    wr_idx   = depth_q[IW-1:0];
    rd_idx   = depth_m1[IW-1:0];
    full     = (depth_q == DW'(DEPTH));
    empty    = (depth_q == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  // NOTE: the stack is cleared on reset because popped entries must read as zero, not X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccr_q   <= 3'b000;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= 3'b000;
    end else if (!stall) begin
      if (int_save) begin
        ccr_q <= ccr_n;
        if (!full) begin
          stack_q[wr_idx] <= ccr_n;
          depth_q         <= depth_q + DW'(1);
        end else begin
          ovf_q <= 1'b1;
        end
      end else if (rti_restore && !empty) begin
        ccr_q   <= stack_q[rd_idx];
        depth_q <= depth_m1;
      end else begin
        ccr_q <= ccr_n;
        if (rti_restore) unf_q <= 1'b1;
      end
    end
  end

  assign depth   = depth_q;
  assign ovf_err = ovf_q;
  assign unf_err = unf_q;
`else
  logic [2:0] shadow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccr_q    <= 3'b000;
      shadow_q <= 3'b000;
    end else if (!stall) begin
      if (int_save) begin
        ccr_q    <= ccr_n;
        shadow_q <= ccr_n;
      end else if (rti_restore) begin
        ccr_q <= shadow_q;
      end else begin
        ccr_q <= ccr_n;
      end
    end
  end

  assign depth   = '0;
  assign ovf_err = 1'b0;
  assign unf_err = 1'b0;
`endif

  assign ccr = ccr_q;

endmodule

// File: tb/tb_ccr_unit.sv
// Directed self-checking bench for ccr_unit; covers both the nested-stack and single-shadow builds.
module tb_ccr_unit;

  localparam int DEPTH = 4;
  localparam int DW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall;
  logic          flag_we;
  logic [2:0]    alu_ccr;
  logic [4:0]    alu_op;
  logic          jump_taken;
  logic          int_save;
  logic          rti_restore;
  logic [2:0]    ccr;
  logic [DW-1:0] depth;
  logic          ovf_err;
  logic          unf_err;

  int vectors     = 0;
  int miscompares = 0;

  ccr_unit #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .flag_we     (flag_we),
    .alu_ccr     (alu_ccr),
    .alu_op      (alu_op),
    .jump_taken  (jump_taken),
    .int_save    (int_save),
    .rti_restore (rti_restore),
    .ccr         (ccr),
    .depth       (depth),
    .ovf_err     (ovf_err),
    .unf_err     (unf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] e_ccr, input int e_depth,
                         input logic e_ovf, input logic e_unf);
    chk({tag, ".ccr"},   8'(ccr),     8'(e_ccr));
    chk({tag, ".depth"}, 8'(depth),   8'(e_depth));
    chk({tag, ".ovf"},   8'(ovf_err), 8'(e_ovf));
    chk({tag, ".unf"},   8'(unf_err), 8'(e_unf));
  endtask

  task automatic drive(input logic we, input logic [2:0] a, input logic [4:0] op,
                       input logic jt, input logic sv, input logic rt, input logic st);
    flag_we = we; alu_ccr = a; alu_op = op; jump_taken = jt;
    int_save = sv; rti_restore = rt; stall = st;
  endtask

  task automatic idle();
    drive(1'b0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One clock: inputs already applied, outputs sampled 1 time unit after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) cycle();
    chk_all("reset_init", 3'b000, 0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Flag load and jump clears
    drive(1'b1, 3'b101, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    chk("load_101", 8'(ccr), 8'b101);
    drive(1'b0, 3'b000, 5'd20, 1'b1, 1'b0, 1'b0, 1'b0); cycle();
    chk("jz_clear", 8'(ccr), 8'b100);
    drive(1'b0, 3'b000, 5'd22, 1'b1, 1'b0, 1'b0, 1'b0); cycle();
    chk("jc_clear", 8'(ccr), 8'b000);
    drive(1'b1, 3'b111, 5'd21, 1'b1, 1'b0, 1'b0, 1'b0); cycle();
    chk("load_jn_clear", 8'(ccr), 8'b101);
    drive(1'b0, 3'b000, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0); cycle();
    chk("jump_other_op", 8'(ccr), 8'b101);
    drive(1'b0, 3'b000, 5'd20, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    chk("jz_not_taken", 8'(ccr), 8'b101);
    drive(1'b1, 3'b111, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    chk("load_111", 8'(ccr), 8'b111);

    // Asynchronous reset mid-cycle, checked before any clock edge
    idle();
    #2 rst_n = 1'b0;
    #1 chk_all("async_reset", 3'b000, 0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cycle();
    chk("post_reset_idle", 8'(ccr), 8'b000);

`ifdef CCR_NEST_EN
    // Nested push / pop
    drive(1'b1, 3'b001, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); cycle();
    drive(1'b1, 3'b010, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); cycle();
    drive(1'b1, 3'b100, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); cycle();
    chk_all("push3", 3'b100, 3, 1'b0, 1'b0);
    drive(1'b0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); cycle();
    chk_all("pop1", 3'b100, 2, 1'b0, 1'b0);
    cycle();
    chk_all("pop2", 3'b010, 1, 1'b0, 1'b0);
    cycle();
    chk_all("pop3", 3'b001, 0, 1'b0, 1'b0);
    drive(1'b1, 3'b011, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); cycle();
    chk_all("underflow", 3'b011, 0, 1'b0, 1'b1);

    // Overflow: five pushes into four entries
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 3'(i), 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); cycle();
    end
    chk_all("overflow", 3'b101, 4, 1'b1, 1'b0);
    drive(1'b0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 4; i >= 1; i--) begin
      cycle();
      chk("ovf_pop", 8'(ccr), 8'(i));
    end
    chk_all("ovf_drained", 3'b001, 0, 1'b1, 1'b0);

    // Save and restore together, then flag_we against a restore
    do_reset();
    drive(1'b1, 3'b110, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); cycle();
    drive(1'b1, 3'b111, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); cycle();
    drive(1'b1, 3'b010, 5'd21, 1'b1, 1'b1, 1'b1, 1'b0); cycle();
    chk_all("save_wins", 3'b000, 3, 1'b0, 1'b0);
    drive(1'b0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); cycle();
    chk_all("pop_saved_n", 3'b000, 2, 1'b0, 1'b0);
    drive(1'b1, 3'b001, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); cycle();
    chk_all("restore_beats_we", 3'b111, 1, 1'b0, 1'b0);
    drive(1'b1, 3'b010, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    chk("we_after_restore", 8'(ccr), 8'b010);

    // Stall freezes everything for three cycles
    drive(1'b1, 3'b111, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk_all("stall_hold", 3'b010, 1, 1'b0, 1'b0);
    end
    drive(1'b1, 3'b111, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); cycle();
    chk_all("stall_release", 3'b111, 2, 1'b0, 1'b0);
    drive(1'b0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1); cycle();
    chk_all("stall_blocks_pop", 3'b111, 2, 1'b0, 1'b0);
`else
    // Single shadow register
    drive(1'b1, 3'b110, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); cycle();
    chk("save_110", 8'(ccr), 8'b110);
    drive(1'b1, 3'b001, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    chk("load_001", 8'(ccr), 8'b001);
    drive(1'b0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); cycle();
    chk_all("restore_110", 3'b110, 0, 1'b0, 1'b0);
    drive(1'b1, 3'b001, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); cycle();
    chk_all("restore_again", 3'b110, 0, 1'b0, 1'b0);
    drive(1'b0, 3'b000, 5'd21, 1'b1, 1'b1, 1'b0, 1'b0); cycle();
    chk("save_jn_clear", 8'(ccr), 8'b100);
    drive(1'b1, 3'b011, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); cycle();
    chk("restore_100", 8'(ccr), 8'b100);
    drive(1'b1, 3'b111, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0); cycle();
    chk("save_wins", 8'(ccr), 8'b111);
    drive(1'b1, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b1, 3'b010, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); cycle();
    chk_all("restore_beats_we", 3'b111, 0, 1'b0, 1'b0);
    drive(1'b1, 3'b000, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk_all("stall_hold", 3'b111, 0, 1'b0, 1'b0);
    end
    drive(1'b1, 3'b000, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); cycle();
    chk("stall_release", 8'(ccr), 8'b000);
    drive(1'b1, 3'b101, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); cycle();
    chk("restore_000", 8'(ccr), 8'b000);
    drive(1'b1, 3'b101, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); cycle();
    do_reset();
    drive(1'b0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); cycle();
    chk("shadow_reset", 8'(ccr), 8'b000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
